hazard_tracker: RTL and testbench
=================================

Name: hazard_tracker

Overview:
- Producer side of the EX-stage operand bypass network in the pipelined LEGv8 CPU.
- Tracks destination-register tags through the ID/EX, EX/MEM and MEM/WB stages, and drives the Rd/RegWrite tags that the forwarding logic compares against.
- Detects load-use hazards, inserts a configurable number of bubbles, and handles taken-branch flushes.
- Counts stall cycles for performance measurement.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (range 1..7).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  IF/ID register holds a real instruction
- id_Rn  input  5  ID-stage source register 1
- id_Rm  input  5  ID-stage source register 2 (Rt for STUR/CBZ)
- id_uses_Rm  input  1  ID instruction reads id_Rm
- id_Rd  input  5  ID-stage destination register
- id_RegWrite  input  1  ID instruction writes the register file
- id_MemRead  input  1  ID instruction is a load (LDUR)
- br_taken  input  1  branch taken, resolved this cycle
- stall  output  1  hold PC and IF/ID (combinational)
- bubble  output  1  load ID/EX with a NOP (combinational)
- flush  output  1  clear IF/ID and ID/EX (combinational, equals br_taken)
- Rd_EX_MEM  output  5  EX/MEM destination tag
- Rd_MEM_WB  output  5  MEM/WB destination tag
- EX_MEM_RegWrite  output  1  EX/MEM valid write
- MEM_WB_RegWrite  output  1  MEM/WB valid write
- stall_cycles  output  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Tag stages: three registered stages, idex, exmem and memwb. Each holds {v, Rd, RegWrite, MemRead}.
- Every cycle, unconditionally: memwb <= exmem; exmem <= idex.
- idex <= invalid (v=0, Rd=31, RegWrite=0, MemRead=0) if flush or bubble. Otherwise idex <= {id_valid, id_Rd, id_RegWrite, id_MemRead}.
- Outputs: Rd_EX_MEM = exmem.Rd; EX_MEM_RegWrite = exmem.v & exmem.RegWrite. MEM_WB outputs follow the same rule from memwb.
- Hazard term: hz = id_valid & idex.v & idex.MemRead & idex.Rd != 31 & (id_Rn == idex.Rd | (id_uses_Rm & id_Rm == idex.Rd)).
- X31 (XZR) never creates a hazard.
- FSM states: RUN, HOLD. A 3-bit bubble counter cnt accompanies the FSM.
- RUN, hz & !br_taken:
  - stall=1, bubble=1 this cycle.
  - If LOAD_USE_BUBBLES > 1: go to HOLD, cnt <= LOAD_USE_BUBBLES-1.
  - Otherwise stay in RUN; the load is in exmem next cycle, so hz clears.
- HOLD:
  - stall=1, bubble=1.
  - cnt decrements; return to RUN in the cycle cnt==1.
  - The hz term is ignored in HOLD.
- br_taken has priority over everything: flush=1, stall=0, bubble=0, FSM goes to RUN, cnt <= 0. This holds even if hz is set or the FSM is in HOLD.
- stall and bubble are always equal; both are 0 in RUN when hz=0.
- stall_cycles increments when stall=1 and holds at 2^CNT_W-1 (no wrap).
- Reset, synchronous, takes priority over all inputs:
  - All tag stages invalid with Rd=31.
  - FSM in RUN, cnt=0, stall_cycles=0.
  - stall, bubble, flush, EX_MEM_RegWrite, MEM_WB_RegWrite all 0; Rd_EX_MEM=Rd_MEM_WB=31.
  - Reset mid-HOLD abandons the stall; the first cycle after reset is RUN with stall=0.
- Latency: an ID instruction's tag appears on Rd_EX_MEM 2 cycles after acceptance and on Rd_MEM_WB 3 cycles after acceptance.

Decomposition:
- Shared cpu package holds:
  - The XZR constant (5'd31).
  - The stage-tag struct {v, Rd[4:0], RegWrite, MemRead} and its invalid constant.
  - The FSM state enum.
- Sub-module stage_tag_reg: one tag pipeline register with a synchronous reset and a load-invalid input. It is instantiated three times.
- The FSM, hazard compare and counter stay in the top level.

Test Plan:
- LDUR X2 then ADD X3,X2,X4, BUBBLES=1:
  - Cycle 2 shows stall=bubble=1 for exactly 1 cycle.
  - The ADD tag reaches exmem 3 cycles after first presentation.
  - stall_cycles=1.
- Same sequence with BUBBLES=3: stall=1 for exactly 3 consecutive cycles, FSM returns to RUN, stall_cycles=3.
- LDUR XZR (X31) followed by ADD X5,X31,X31: stall never asserts; tags still propagate with Rd=31 and RegWrite=1.
- br_taken asserted in the first HOLD cycle (BUBBLES=3):
  - flush=1, stall=0 that cycle, idex invalid next cycle.
  - FSM in RUN; stall_cycles=1.
- Back-to-back writers ADD X1 then SUB X1:
  - Rd_EX_MEM=1 / EX_MEM_RegWrite=1 and Rd_MEM_WB=1 / MEM_WB_RegWrite=1 on successive cycles.
  - No stall asserts.
- reset pulsed in mid-HOLD, and stall_cycles preset near saturation with CNT_W=4:
  - Mid-HOLD reset clears all outputs to their reset values.
  - With CNT_W=4, the count saturates at 15 during continuous stalls.

Source files
------------

// File: rtl/hazard_tracker_pkg.sv
// Shared types for the EX-stage bypass producer:
// register tags, the invalid tag and the hazard FSM states.
package hazard_tracker_pkg;

   localparam logic [4:0] XZR = 5'd31;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } stage_tag_t;

   localparam stage_tag_t TAG_INVALID = '{
      v:         1'b0,
      rd:        XZR,
      reg_write: 1'b0,
      mem_read:  1'b0
   };

   typedef enum logic {
      RUN,
      HOLD
   } hz_state_e;

endpackage

// File: rtl/hazard_tracker_stage_tag_reg.sv
// One destination-tag pipeline register; reset and
// load_invalid both force the invalid tag.
module stage_tag_reg
   import hazard_tracker_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load_invalid,
   input  stage_tag_t d,
   output stage_tag_t q
);

   always_ff @(posedge clk) begin
      if (reset || load_invalid)
         q <= TAG_INVALID;
      else
         q <= d;
   end

endmodule

// File: rtl/hazard_tracker.sv
// Load-use hazard detection, bubble insertion, branch flush
// and destination-tag tracking for the EX-stage bypass.
module hazard_tracker
   import hazard_tracker_pkg::*;
#(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_Rn,
   input  logic [4:0]       id_Rm,
   input  logic             id_uses_Rm,
   input  logic [4:0]       id_Rd,
   input  logic             id_RegWrite,
   input  logic             id_MemRead,
   input  logic             br_taken,
   output logic             stall,
   output logic             bubble,
   output logic             flush,
   output logic [4:0]       Rd_EX_MEM,
   output logic [4:0]       Rd_MEM_WB,
   output logic             EX_MEM_RegWrite,
   output logic             MEM_WB_RegWrite,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [2:0] HOLD_INIT = 3'(LOAD_USE_BUBBLES - 1);

   stage_tag_t idex_d, idex_q, exmem_q, memwb_q;
   hz_state_e  state, state_n;
   logic [2:0] cnt, cnt_n;
   logic       hz;

   assign idex_d = '{
      v:         id_valid,
      rd:        id_Rd,
      reg_write: id_RegWrite,
      mem_read:  id_MemRead
   };

   stage_tag_reg u_idex (
      .clk          (clk),
      .reset        (reset),
      .load_invalid (flush | bubble),
      .d            (idex_d),
      .q            (idex_q)
   );

   stage_tag_reg u_exmem (
      .clk          (clk),
      .reset        (reset),
      .load_invalid (1'b0),
      .d            (idex_q),
      .q            (exmem_q)
   );

   stage_tag_reg u_memwb (
      .clk          (clk),
      .reset        (reset),
      .load_invalid (1'b0),
      .d            (exmem_q),
      .q            (memwb_q)
   );

   // XZR never carries a real value, so it never blocks a consumer
   assign hz = id_valid && idex_q.v && idex_q.mem_read
            && (idex_q.rd != XZR)
            && ((id_Rn == idex_q.rd)
             || (id_uses_Rm && (id_Rm == idex_q.rd)));

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      stall   = 1'b0;
      if (br_taken) begin
         state_n = RUN;
         cnt_n   = 3'd0;
      end else begin
         unique case (state)
            RUN: begin
               if (hz) begin
                  stall = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     state_n = HOLD;
                     cnt_n   = HOLD_INIT;
                  end
               end
            end
            HOLD: begin
               stall = 1'b1;
               cnt_n = cnt - 3'd1;
               if (cnt == 3'd1)
                  state_n = RUN;
            end
            default: state_n = RUN;
         endcase
      end
   end

   assign bubble = stall;
   assign flush  = br_taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         cnt          <= 3'd0;
         stall_cycles <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   assign Rd_EX_MEM       = exmem_q.rd;
   assign EX_MEM_RegWrite = exmem_q.v & exmem_q.reg_write;
   assign Rd_MEM_WB       = memwb_q.rd;
   assign MEM_WB_RegWrite = memwb_q.v & memwb_q.reg_write;

endmodule

// File: tb/tb_hazard_tracker.sv
// Three hazard_tracker builds (1/3/7 bubbles) on one stimulus
// stream, each checked against a cycle-level reference model.
module tb_hazard_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_Rn, id_Rm, id_Rd;
   logic       id_uses_Rm, id_RegWrite, id_MemRead;
   logic       br_taken;

   logic       st [3];
   logic       bb [3];
   logic       fl [3];
   logic [4:0] rdem [3];
   logic [4:0] rdmw [3];
   logic       rwem [3];
   logic       rwmw [3];
   logic [31:0] sc0;
   logic [3:0]  sc1, sc2;
   logic [31:0] scx [3];

   assign scx[0] = sc0;
   assign scx[1] = {28'd0, sc1};
   assign scx[2] = {28'd0, sc2};

   always #5 clk = ~clk;

   hazard_tracker #(.LOAD_USE_BUBBLES(1), .CNT_W(32)) u_b1 (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_Rn(id_Rn), .id_Rm(id_Rm), .id_uses_Rm(id_uses_Rm),
      .id_Rd(id_Rd), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .br_taken(br_taken),
      .stall(st[0]), .bubble(bb[0]), .flush(fl[0]),
      .Rd_EX_MEM(rdem[0]), .Rd_MEM_WB(rdmw[0]),
      .EX_MEM_RegWrite(rwem[0]), .MEM_WB_RegWrite(rwmw[0]),
      .stall_cycles(sc0)
   );

   hazard_tracker #(.LOAD_USE_BUBBLES(3), .CNT_W(4)) u_b3 (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_Rn(id_Rn), .id_Rm(id_Rm), .id_uses_Rm(id_uses_Rm),
      .id_Rd(id_Rd), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .br_taken(br_taken),
      .stall(st[1]), .bubble(bb[1]), .flush(fl[1]),
      .Rd_EX_MEM(rdem[1]), .Rd_MEM_WB(rdmw[1]),
      .EX_MEM_RegWrite(rwem[1]), .MEM_WB_RegWrite(rwmw[1]),
      .stall_cycles(sc1)
   );

   hazard_tracker #(.LOAD_USE_BUBBLES(7), .CNT_W(4)) u_b7 (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_Rn(id_Rn), .id_Rm(id_Rm), .id_uses_Rm(id_uses_Rm),
      .id_Rd(id_Rd), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .br_taken(br_taken),
      .stall(st[2]), .bubble(bb[2]), .flush(fl[2]),
      .Rd_EX_MEM(rdem[2]), .Rd_MEM_WB(rdmw[2]),
      .EX_MEM_RegWrite(rwem[2]), .MEM_WB_RegWrite(rwmw[2]),
      .stall_cycles(sc2)
   );

   // reference model: a 3-deep tag queue plus "stall cycles left"
   typedef struct {
      bit v;
      int rd;
      bit rw;
      bit mr;
   } mtag_t;

   mtag_t  pipe [3][3];
   int     left [3];
   longint cnt  [3];
   int     nbub [3] = '{1, 3, 7};
   longint cmax [3] = '{64'hFFFF_FFFF, 15, 15};

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int s = 0; s < 3; s++)
            pipe[i][s] = '{v: 0, rd: 31, rw: 0, mr: 0};
         left[i] = 0;
         cnt[i]  = 0;
      end
   endtask

   task automatic tick(input bit r, input bit v,
                       input int rn, input int rm, input bit urm,
                       input int rd, input bit rw, input bit mr,
                       input bit br);
      bit hz, est;
      mtag_t nt;
      @(negedge clk);
      reset       = r;
      id_valid    = v;
      id_Rn       = 5'(rn);
      id_Rm       = 5'(rm);
      id_uses_Rm  = urm;
      id_Rd       = 5'(rd);
      id_RegWrite = rw;
      id_MemRead  = mr;
      br_taken    = br;
      #1;
      if (r) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         hz = v && pipe[i][0].v && pipe[i][0].mr
           && pipe[i][0].rd != 31
           && (rn == pipe[i][0].rd
               || (urm && rm == pipe[i][0].rd));
         est = !br && (left[i] > 0 || hz);
         chk($sformatf("u%0d_stall", i), 32'(st[i]), 32'(est));
         chk($sformatf("u%0d_bubble", i), 32'(bb[i]), 32'(est));
         chk($sformatf("u%0d_flush", i), 32'(fl[i]), 32'(br));
         chk($sformatf("u%0d_rd_exmem", i), 32'(rdem[i]),
             32'(pipe[i][1].rd));
         chk($sformatf("u%0d_rw_exmem", i), 32'(rwem[i]),
             32'(pipe[i][1].v && pipe[i][1].rw));
         chk($sformatf("u%0d_rd_memwb", i), 32'(rdmw[i]),
             32'(pipe[i][2].rd));
         chk($sformatf("u%0d_rw_memwb", i), 32'(rwmw[i]),
             32'(pipe[i][2].v && pipe[i][2].rw));
         chk($sformatf("u%0d_stall_cycles", i), scx[i],
             32'(cnt[i]));
         if (br)
            left[i] = 0;
         else if (left[i] > 0)
            left[i]--;
         else if (hz)
            left[i] = nbub[i] - 1;
         if (est && cnt[i] < cmax[i])
            cnt[i]++;
         if (br || est)
            nt = '{v: 0, rd: 31, rw: 0, mr: 0};
         else
            nt = '{v: v, rd: rd, rw: rw, mr: mr};
         pipe[i][2] = pipe[i][1];
         pipe[i][1] = pipe[i][0];
         pipe[i][0] = nt;
      end
   endtask

   task automatic do_reset();
      tick(1, 0, 0, 0, 0, 31, 0, 0, 0);
   endtask

   task automatic nop(input int n);
      for (int k = 0; k < n; k++)
         tick(0, 0, 0, 0, 0, 31, 0, 0, 0);
   endtask

   function automatic int pick_reg();
      int r;
      r = int'($urandom_range(0, 5));
      return (r == 5) ? 31 : r;
   endfunction

   initial begin
      reset = 1'b1;
      id_valid = 0; id_Rn = 0; id_Rm = 0; id_uses_Rm = 0;
      id_Rd = 31; id_RegWrite = 0; id_MemRead = 0;
      br_taken = 0;
      model_reset();

      // LDUR X2 ; ADD X3,X2,X4 held while stalled
      do_reset();
      nop(1);
      tick(0, 1, 0, 0, 0, 2, 1, 1, 0);
      for (int k = 0; k < 8; k++)
         tick(0, 1, 2, 4, 1, 3, 1, 0, 0);
      nop(4);
      chk("ldu_sc_b1", scx[0], 32'd1);
      chk("ldu_sc_b3", scx[1], 32'd3);
      chk("ldu_sc_b7", scx[2], 32'd7);

      // LDUR XZR ; ADD X5,X31,X31 never stalls
      do_reset();
      tick(0, 1, 0, 0, 0, 31, 1, 1, 0);
      tick(0, 1, 31, 31, 1, 5, 1, 0, 0);
      nop(3);
      chk("xzr_sc_b3", scx[1], 32'd0);

      // branch in the first HOLD cycle
      do_reset();
      tick(0, 1, 0, 0, 0, 2, 1, 1, 0);
      tick(0, 1, 2, 4, 1, 3, 1, 0, 0);
      tick(0, 1, 2, 4, 1, 3, 1, 0, 1);
      nop(3);
      chk("br_sc_b3", scx[1], 32'd1);
      chk("br_sc_b7", scx[2], 32'd1);

      // back-to-back writers ADD X1 ; SUB X1
      do_reset();
      tick(0, 1, 2, 3, 1, 1, 1, 0, 0);
      tick(0, 1, 1, 3, 1, 1, 1, 0, 0);
      nop(3);
      chk("b2b_sc_b1", scx[0], 32'd0);

      // reset while the 7-bubble build is holding
      do_reset();
      tick(0, 1, 0, 0, 0, 2, 1, 1, 0);
      tick(0, 1, 2, 4, 1, 3, 1, 0, 0);
      tick(0, 1, 2, 4, 1, 3, 1, 0, 0);
      do_reset();
      tick(0, 0, 0, 0, 0, 31, 0, 0, 0);
      chk("rst_hold_stall", 32'(st[2]), 32'd0);
      chk("rst_hold_sc", scx[2], 32'd0);

      // saturation of the 4-bit counters
      do_reset();
      for (int k = 0; k < 6; k++) begin
         tick(0, 1, 0, 0, 0, 1, 1, 1, 0);
         for (int j = 0; j < 8; j++)
            tick(0, 1, 1, 0, 0, 4, 1, 0, 0);
      end
      chk("sat_sc_b1", scx[0], 32'd6);
      chk("sat_sc_b3", scx[1], 32'd15);
      chk("sat_sc_b7", scx[2], 32'd15);

      // random traffic
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         bit w, ld;
         w  = ($urandom_range(0, 3) != 0);
         ld = w && ($urandom_range(0, 2) == 0);
         tick(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 5) != 0),
              pick_reg(), pick_reg(),
              $urandom_range(0, 1) == 1,
              pick_reg(), w, ld,
              ($urandom_range(0, 9) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
